// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: I-cache address/data, decode stall, EX redirect and the IF/ID outputs.
interface inst_fetch_unit_if;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        output icache_addr,
        input  icache_rdata,
        input  icache_stall,
        input  id_stall,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_pc,
        output if_instr
    );

    modport slave (
        input  icache_addr,
        output icache_rdata,
        output icache_stall,
        output id_stall,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_pc,
        input  if_instr
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache and fills the IF/ID register.
// Tracks cache misses and redirects that arrive while a refill is in flight.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              proc_reset,
    inst_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        MISS       = 2'd1,
        MISS_REDIR = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_nxt;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt;
    logic [31:0] redir_tgt;
    logic        ifid_load;
    logic        ifid_bubble;
    logic        valid_q;
    logic [31:0] ipc_q;
    logic [31:0] instr_q;

    assign redir_tgt = bus.redirect_pc & ~32'd3;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state   <= FETCH;
            pend_pc <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_nxt;
        end
    end

    // Latest redirect seen during a refill wins.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_pc;
        if (bus.icache_stall) begin
            if (bus.redirect_valid) begin
                state_nxt = MISS_REDIR;
                pend_nxt  = redir_tgt;
            end else if (state == FETCH) begin
                state_nxt = MISS;
            end
        end else begin
            state_nxt = FETCH;
        end
    end

    always_comb begin
        pc_nxt      = pc_r;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (bus.icache_stall) begin
            ifid_bubble = bus.redirect_valid || !bus.id_stall;
        end else if (bus.redirect_valid) begin
            pc_nxt      = redir_tgt;
            ifid_bubble = 1'b1;
        end else if (state == MISS_REDIR) begin
            pc_nxt      = pend_pc;
            ifid_bubble = 1'b1;
        end else if (!bus.id_stall) begin
            pc_nxt    = pc_r + 32'd4;
            ifid_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            pc_r    <= RESET_PC;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            pc_r <= pc_nxt;
            if (ifid_bubble) begin
                valid_q <= 1'b0;
                ipc_q   <= '0;
                instr_q <= NOP_INSTR;
            end else if (ifid_load) begin
                valid_q <= 1'b1;
                ipc_q   <= pc_r;
                instr_q <= bus.icache_rdata;
            end
        end
    end

    assign bus.icache_addr = pc_r[31:2];
    assign bus.if_valid    = valid_q;
    assign bus.if_pc       = ipc_q;
    assign bus.if_instr    = instr_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios plus randomized traffic
// checked against a behavioural fetch model.
module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic proc_reset;
    int   checks;
    int   errors;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'h1357_9BDF;
    endfunction

    // Cache model: data only valid on a hit, junk during refill.
    assign bus.icache_rdata = bus.icache_stall ? 32'hDEAD_BEEF
                                               : mem_word(bus.icache_addr);

    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend;
    logic        m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;

    task automatic m_bubble();
        m_v     = 1'b0;
        m_ipc   = 32'd0;
        m_instr = NOP;
    endtask

    task automatic model_step(input logic rst, input logic st,
                              input logic ids, input logic rv,
                              input logic [31:0] rpc);
        if (rst) begin
            m_pc     = 32'd0;
            m_pend_v = 1'b0;
            m_pend   = 32'd0;
            m_bubble();
        end else if (st) begin
            if (rv) begin
                m_pend_v = 1'b1;
                m_pend   = {rpc[31:2], 2'b00};
            end
            if (rv || !ids) m_bubble();
        end else if (rv) begin
            m_pc     = {rpc[31:2], 2'b00};
            m_pend_v = 1'b0;
            m_bubble();
        end else if (m_pend_v) begin
            m_pc     = m_pend;
            m_pend_v = 1'b0;
            m_bubble();
        end else if (!ids) begin
            m_v     = 1'b1;
            m_ipc   = m_pc;
            m_instr = mem_word(m_pc[31:2]);
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input logic ids,
                         input logic rv, input logic [31:0] rpc);
        proc_reset         = rst;
        bus.icache_stall   = st;
        bus.id_stall       = ids;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        model_step(rst, st, ids, rv, rpc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, $urandom);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.if_pc !== 32'd0 ||
            bus.if_instr !== NOP || bus.icache_addr !== 30'd0) begin
            errors++;
            $display("FAIL reset: valid=%b pc=%h instr=%h addr=%h",
                     bus.if_valid, bus.if_pc, bus.if_instr, bus.icache_addr);
        end
    endtask

    task automatic test_stream();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(i * 4) ||
                bus.if_instr !== mem_word(30'(i)) ||
                bus.icache_addr !== 30'(i + 1)) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h addr=%h",
                         i, bus.if_valid, bus.if_pc, bus.if_instr,
                         bus.icache_addr);
            end
        end
    endtask

    task automatic test_miss();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
            checks++;
            if (bus.icache_addr !== 30'h4 || bus.if_valid !== 1'b0) begin
                errors++;
                $display("FAIL miss_hold[%0d]: addr=%h valid=%b want 4/0",
                         i, bus.icache_addr, bus.if_valid);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h10 ||
            bus.if_instr !== mem_word(30'h4)) begin
            errors++;
            $display("FAIL miss_done: valid=%b pc=%h instr=%h want 1/10/%h",
                     bus.if_valid, bus.if_pc, bus.if_instr, mem_word(30'h4));
        end
    endtask

    task automatic test_redirect();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h203);
        checks++;
        if (bus.icache_addr !== 30'h80 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_bubble: addr=%h valid=%b want 80/0",
                     bus.icache_addr, bus.if_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 ||
            bus.if_instr !== mem_word(30'h80)) begin
            errors++;
            $display("FAIL redir_target: valid=%b pc=%h instr=%h want 1/200",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_miss_redirect();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.icache_addr !== 30'h8 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL missredir_hold: addr=%h valid=%b want 8/0",
                     bus.icache_addr, bus.if_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.icache_addr !== 30'h20 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL missredir_bubble: addr=%h valid=%b want 20/0",
                     bus.icache_addr, bus.if_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h80 ||
            bus.if_instr !== mem_word(30'h20)) begin
            errors++;
            $display("FAIL missredir_target: valid=%b pc=%h want 1/80",
                     bus.if_valid, bus.if_pc);
        end
    endtask

    task automatic test_id_stall();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC ||
                bus.if_instr !== mem_word(30'h3) ||
                bus.icache_addr !== 30'h4) begin
                errors++;
                $display("FAIL id_stall[%0d]: valid=%b pc=%h addr=%h",
                         i, bus.if_valid, bus.if_pc, bus.icache_addr);
            end
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        checks++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== NOP ||
            bus.icache_addr !== 30'h40) begin
            errors++;
            $display("FAIL id_stall_flush: valid=%b instr=%h addr=%h",
                     bus.if_valid, bus.if_instr, bus.icache_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.if_pc !== 32'hFFFF_FFFC || bus.if_valid !== 1'b1 ||
            bus.icache_addr !== 30'h0) begin
            errors++;
            $display("FAIL wrap: pc=%h valid=%b addr=%h want fffffffc/1/0",
                     bus.if_pc, bus.if_valid, bus.icache_addr);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h600);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.icache_addr !== 30'h0 || bus.if_valid !== 1'b0) begin
            errors++;
            $display("FAIL midmiss_reset: addr=%h valid=%b want 0/0",
                     bus.icache_addr, bus.if_valid);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 ||
            bus.icache_addr !== 30'h1) begin
            errors++;
            $display("FAIL reset_drops_pend: valid=%b pc=%h addr=%h",
                     bus.if_valid, bus.if_pc, bus.icache_addr);
        end
    endtask

    task automatic test_random();
        logic        st;
        logic        ids;
        logic        rv;
        logic [31:0] rpc;
        logic [29:0] addr_before;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 600; i++) begin
            st          = ($urandom_range(0, 99) < 30);
            ids         = ($urandom_range(0, 99) < 25);
            rv          = ($urandom_range(0, 99) < 15);
            rpc         = $urandom;
            addr_before = bus.icache_addr;
            cycle(1'b0, st, ids, rv, rpc);
            checks++;
            if (bus.if_valid !== m_v || bus.if_pc !== m_ipc ||
                bus.if_instr !== m_instr ||
                bus.icache_addr !== m_pc[31:2]) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b pc=%h i=%h a=%h want v=%b pc=%h i=%h a=%h",
                         i, bus.if_valid, bus.if_pc, bus.if_instr,
                         bus.icache_addr, m_v, m_ipc, m_instr, m_pc[31:2]);
            end
            if (st) begin
                checks++;
                if (bus.icache_addr !== addr_before) begin
                    errors++;
                    $display("FAIL addr_stable[%0d]: addr=%h want %h",
                             i, bus.icache_addr, addr_before);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_miss();
        test_redirect();
        test_miss_redirect();
        test_id_stall();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
